// File: rtl/booth_multiplier.sv
// Sequential radix-2 Booth multiplier: captures signed M/Q on load, then runs one
// add/subtract-and-shift step per clock and registers the 2*WIDTH-bit product on P.
module booth_multiplier #(
  parameter int unsigned WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load,
  input  logic [WIDTH-1:0]     M,
  input  logic [WIDTH-1:0]     Q,
  output logic [2*WIDTH-1:0]   P
);

  localparam int unsigned CntW = $clog2(WIDTH) + 1;

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  state_e               state_q, state_d;
  // Accumulator and multiplicand carry one guard bit so -M of the most negative M fits.
  logic [WIDTH:0]       a_q, a_d;
  logic [WIDTH:0]       m_q, m_d;
  logic [WIDTH-1:0]     q_q, q_d;
  logic                 q_1_q, q_1_d;
  logic [CntW-1:0]      count_q, count_d;
  logic [2*WIDTH-1:0]   p_q, p_d;

  logic [WIDTH:0]       t;
  logic [WIDTH:0]       a_new;
  logic [WIDTH-1:0]     q_new;

  // One Booth step, computed every cycle and only committed while busy.
  always_comb begin
    case ({q_q[0], q_1_q})
      2'b01:   t = a_q + m_q;
      2'b10:   t = a_q - m_q;
      default: t = a_q;
    endcase
    a_new = {t[WIDTH], t[WIDTH:1]};
    q_new = {t[0], q_q[WIDTH-1:1]};
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    m_d     = m_q;
    q_d     = q_q;
    q_1_d   = q_1_q;
    count_d = count_q;
    p_d     = p_q;

    if (load) begin
      // Capture restarts from scratch in either state; any in-flight result is dropped.
      m_d     = {M[WIDTH-1], M};
      q_d     = Q;
      a_d     = '0;
      q_1_d   = 1'b0;
      count_d = CntW'(WIDTH);
      state_d = StBusy;
    end else if (state_q == StBusy) begin
      a_d     = a_new;
      q_d     = q_new;
      q_1_d   = q_q[0];
      count_d = count_q - CntW'(1);
      if (count_q == CntW'(1)) begin
        p_d     = {a_new[WIDTH-1:0], q_new};
        state_d = StIdle;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      a_q     <= '0;
      m_q     <= '0;
      q_q     <= '0;
      q_1_q   <= 1'b0;
      count_q <= '0;
      p_q     <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      m_q     <= m_d;
      q_q     <= q_d;
      q_1_q   <= q_1_d;
      count_q <= count_d;
      p_q     <= p_d;
    end
  end

  assign P = p_q;

endmodule

// File: tb/tb_booth_multiplier.sv
// Scoreboard bench for booth_multiplier: expected products are queued at load time
// and compared when the product is due, 32 clocks after the final load edge.
module tb_booth_multiplier;

  logic        clk;
  logic        reset;
  logic        load;
  logic [31:0] M;
  logic [31:0] Q;
  logic [63:0] P;

  int          n_checks;
  int          n_errors;
  longint      exp_q[$];
  logic [63:0] p_prev;

  booth_multiplier #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .load  (load),
    .M     (M),
    .Q     (Q),
    .P     (P)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d required %0d", tag, $signed(obs), $signed(exp));
    end
  endtask

  // Presents operands for one load edge and queues the expected product.
  task automatic start_op(input logic [31:0] m, input logic [31:0] q, input longint exp);
    @(negedge clk);
    M    = m;
    Q    = q;
    load = 1'b1;
    exp_q.push_back(exp);
    @(negedge clk);
    load = 1'b0;
  endtask

  // P must hold its old value for 31 cycles, then show the product on the 32nd.
  task automatic finish_op(input string tag);
    logic [63:0] seen;
    longint      exp;
    seen = p_prev;
    for (int i = 0; i < 31; i++) begin
      @(negedge clk);
      if (P !== p_prev && seen === p_prev) seen = P;
    end
    check_eq({tag, "_hold"}, seen, p_prev);
    @(negedge clk);
    if (exp_q.size() == 0) begin
      check_eq({tag, "_noexp"}, P, ~P);
    end else begin
      exp = exp_q.pop_front();
      check_eq(tag, P, exp);
      p_prev = exp;
    end
  endtask

  task automatic run_op(input string tag, input logic [31:0] m, input logic [31:0] q,
                        input longint exp);
    start_op(m, q, exp);
    finish_op(tag);
  endtask

  initial begin
    logic signed [31:0] rm, rq;
    longint             lm, lq;
    n_checks = 0;
    n_errors = 0;
    p_prev   = '0;
    reset    = 1'b0;
    load     = 1'b0;
    M        = '0;
    Q        = '0;
    repeat (3) @(negedge clk);
    check_eq("reset_p", P, 64'd0);
    reset = 1'b1;

    run_op("neg_neg",   -32'sd5,  -32'sd6,  64'sd30);
    run_op("pos_pos",   32'sd5,   32'sd6,   64'sd30);
    run_op("neg_pos",   -32'sd7,  32'sd4,   -64'sd28);
    run_op("pos_neg",   32'sd10,  -32'sd3,  -64'sd30);
    run_op("m1_65535",  -32'sd1,  32'sd65535, -64'sd65535);
    run_op("max_min",   32'h7fffffff, 32'h80000000, -64'sd4611686016279904256);
    run_op("min_2",     32'h80000000, 32'sd2, -64'sd4294967296);
    run_op("min_min",   32'h80000000, 32'h80000000, 64'sd4611686018427387904);
    run_op("large_pp",  32'sd16777215, 32'sd16777213, 64'sd281474909601795);
    run_op("large_nn",  -32'sd16777215, -32'sd16777213, 64'sd281474909601795);
    run_op("zero_m",    32'sd0, 32'sd65535, 64'sd0);

    // Async reset ten cycles into a run clears P without waiting for a clock edge.
    start_op(32'sd15, 32'sd15, 64'sd225);
    repeat (10) @(negedge clk);
    #2 reset = 1'b0;
    #1 check_eq("reset_async", P, 64'd0);
    exp_q.delete();
    p_prev = '0;
    @(negedge clk);
    #2 reset = 1'b1;
    run_op("after_reset", 32'sd15, 32'sd15, 64'sd225);

    // Reload mid-run: the first operand pair must never reach P.
    start_op(32'sd7, 32'sd9, 64'sd63);
    repeat (10) @(negedge clk);
    exp_q.delete();
    run_op("reload", 32'sd3, -32'sd4, -64'sd12);

    // Load held over several edges: only the last capture counts, timed from it.
    @(negedge clk);
    M    = 32'sd100;
    Q    = 32'sd100;
    load = 1'b1;
    @(negedge clk);
    M    = -32'sd3;
    Q    = 32'sd7;
    exp_q.push_back(-64'sd21);
    @(negedge clk);
    load = 1'b0;
    finish_op("load_held");

    for (int i = 0; i < 4; i++) begin
      rm = $urandom;
      rq = $urandom;
      lm = rm;
      lq = rq;
      run_op($sformatf("rand%0d", i), rm, rq, lm * lq);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
